// File: rtl/ej32_pkg.sv
// Purpose: shared types and constants for the eJ32 data-stack spill/fill controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ej32_pkg;

   // Spill/fill controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SP_RD = 3'd1,
      SP_WR = 3'd2,
      FL_RD = 3'd3,
      FL_WR = 3'd4
   } ss_ctl_t;

   localparam int          SS_DEPTH = 32;       // EBR stack entries
   localparam int          SS_DSZ   = 32;       // data width
   localparam int          SS_ASZ   = 16;       // memory byte-address width
   localparam int          SS_HI    = 28;       // spill threshold (resident count)
   localparam int          SS_LO    = 4;        // fill threshold (resident count)
   localparam int          SS_CHUNK = 8;        // words per burst
   localparam int          SS_MAXW  = 1024;     // spill-area capacity in words
   localparam int unsigned SS_BASE  = 32'h8000; // spill-area byte base

endpackage

// File: rtl/ej32_ss_spill.sv
// Purpose: spill/fill controller for the eJ32 data-stack EBR ring; moves the oldest
//          entries to a memory spill area when nearly full and brings them back when nearly empty.
// Latency: burst decision one cycle after cnt crosses a threshold; 2+ cycles per word (EBR + memory ack).
// Backpressure: stalls the AU (stall_o) for the whole burst; memory request held until mem_ack_i.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_i, pop_i, sp_i AU stack-op decode and ring top index (ignored while stall_o=1)
//   stall_o             holds the AU while a burst runs
//   ebr_*               controller side of the stack EBR second port (1-cycle read latency)
//   mem_*               single-word memory requests to the arbiter, held until mem_ack_i
//   cnt_o               resident entry count; ovf_o / udf_o sticky overflow / underflow
module ej32_ss_spill
   import ej32_pkg::*;
#(
   parameter int          DEPTH = SS_DEPTH,
   parameter int          DSZ   = SS_DSZ,
   parameter int          ASZ   = SS_ASZ,
   parameter int          HI    = SS_HI,
   parameter int          LO    = SS_LO,
   parameter int          CHUNK = SS_CHUNK,
   parameter int          MAXW  = SS_MAXW,
   parameter int unsigned BASE  = SS_BASE,
   localparam int         SPW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push_i,
   input  logic           pop_i,
   input  logic [SPW-1:0] sp_i,
   output logic           stall_o,
   output logic [SPW-1:0] ebr_addr_o,
   output logic           ebr_ren_o,
   output logic           ebr_wen_o,
   output logic [DSZ-1:0] ebr_wdata_o,
   input  logic [DSZ-1:0] ebr_rdata_i,
   output logic           mem_req_o,
   output logic           mem_we_o,
   output logic [ASZ-1:0] mem_addr_o,
   output logic [DSZ-1:0] mem_wdata_o,
   input  logic [DSZ-1:0] mem_rdata_i,
   input  logic           mem_ack_i,
   output logic [SPW:0]   cnt_o,
   output logic           ovf_o,
   output logic           udf_o
);

   localparam int SPILLW = $clog2(MAXW) + 1;
   localparam int BCW    = $clog2(CHUNK) + 1;

   localparam logic [SPW:0]      DEPTH_C = (SPW+1)'(DEPTH);
   localparam logic [SPW:0]      HI_C    = (SPW+1)'(HI);
   localparam logic [SPW:0]      LO_C    = (SPW+1)'(LO);
   localparam logic [SPW:0]      CNT_ONE = (SPW+1)'(1);
   localparam logic [SPILLW-1:0] MAXW_C  = SPILLW'(MAXW);
   localparam logic [SPILLW-1:0] SPL_ONE = SPILLW'(1);
   localparam logic [BCW-1:0]    CHUNK_C = BCW'(CHUNK);
   localparam logic [BCW-1:0]    BC_ONE  = BCW'(1);
   localparam logic [ASZ-1:0]    BASE_C  = ASZ'(BASE);

   ss_ctl_t           state_q, state_d;
   logic [SPW:0]      cnt_q, cnt_d;
   logic [SPILLW-1:0] spilled_q, spilled_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic [DSZ-1:0]    data_q, data_d;
   logic              rd_vld_q, rd_vld_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic [SPW-1:0]    bottom;
   logic [SPILLW-1:0] spilled_inc;
   logic [SPILLW-1:0] spilled_dec;
   logic [BCW-1:0]    bcnt_inc;
   logic [SPILLW-1:0] mem_idx;

   // Oldest resident entry in the ring; cnt=DEPTH wraps to sp+1 by truncation.
   assign bottom      = sp_i - cnt_q[SPW-1:0] + SPW'(1);
   assign spilled_inc = spilled_q + SPL_ONE;
   assign spilled_dec = spilled_q - SPL_ONE;
   assign bcnt_inc    = bcnt_q + BC_ONE;
   // Spill writes the next free word; fill reads back the most recently spilled word.
   assign mem_idx     = (state_q == FL_RD) ? spilled_dec : spilled_q;

   assign stall_o = (state_q != IDLE);
   assign cnt_o   = cnt_q;
   assign ovf_o   = ovf_q;
   assign udf_o   = udf_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      spilled_d   = spilled_q;
      bcnt_d      = bcnt_q;
      data_d      = data_q;
      rd_vld_d    = 1'b0;
      ovf_d       = ovf_q;
      udf_d       = udf_q;
      ebr_addr_o  = '0;
      ebr_ren_o   = 1'b0;
      ebr_wen_o   = 1'b0;
      ebr_wdata_o = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      case (state_q)
         IDLE: begin
            if (push_i && !pop_i) begin
               if (cnt_q == DEPTH_C) begin
                  if (spilled_q == MAXW_C) ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else if (pop_i && !push_i) begin
               if (cnt_q == '0) begin
                  if (spilled_q == '0) udf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            // Decision uses the registered count; an op accepted this cycle
            // is folded into cnt_d and seen by the burst from the next cycle.
            if (cnt_q >= HI_C && spilled_q < MAXW_C) begin
               state_d = SP_RD;
               bcnt_d  = '0;
            end else if (cnt_q <= LO_C && spilled_q != '0) begin
               state_d = FL_RD;
               bcnt_d  = '0;
            end
         end

         SP_RD: begin
            ebr_ren_o  = 1'b1;
            ebr_addr_o = bottom;
            rd_vld_d   = 1'b1;
            state_d    = SP_WR;
         end

         SP_WR: begin
            // EBR data arrives in the first SP_WR cycle only; forward it then
            // and hold the captured copy for the rest of the request.
            if (rd_vld_q) data_d = ebr_rdata_i;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = BASE_C + ASZ'({mem_idx, 2'b00});
            mem_wdata_o = rd_vld_q ? ebr_rdata_i : data_q;
            if (mem_ack_i) begin
               spilled_d = spilled_inc;
               cnt_d     = cnt_q - CNT_ONE;
               bcnt_d    = bcnt_inc;
               state_d   = (bcnt_inc < CHUNK_C && spilled_inc < MAXW_C) ? SP_RD : IDLE;
            end
         end

         FL_RD: begin
            mem_req_o  = 1'b1;
            mem_addr_o = BASE_C + ASZ'({mem_idx, 2'b00});
            if (mem_ack_i) begin
               data_d  = mem_rdata_i;
               state_d = FL_WR;
            end
         end

         FL_WR: begin
            ebr_wen_o   = 1'b1;
            ebr_addr_o  = bottom - SPW'(1);
            ebr_wdata_o = data_q;
            spilled_d   = spilled_dec;
            cnt_d       = cnt_q + CNT_ONE;
            bcnt_d      = bcnt_inc;
            state_d     = (bcnt_inc < CHUNK_C && spilled_dec != '0) ? FL_RD : IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         spilled_q <= '0;
         bcnt_q    <= '0;
         data_q    <= '0;
         rd_vld_q  <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         spilled_q <= spilled_d;
         bcnt_q    <= bcnt_d;
         data_q    <= data_d;
         rd_vld_q  <= rd_vld_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

endmodule

// File: doc/ej32_ss_spill.md
Name: ej32_ss_spill

Overview:
Spill/fill controller for the eJ32 data stack EBR (32-entry ring addressed by the AU stack pointer).
- Tracks resident depth.
- Near full, moves the oldest CHUNK entries to a memory-backed spill area; near empty, refills them.
- Stalls the AU (au_en gating) during each burst.
- Sits between the AU stack-op decode, the stack EBR second port and the memory bus arbiter.

Parameters:
DEPTH, 32, EBR stack entries (power of 2); SPW = log2(DEPTH)
DSZ, 32, data width
ASZ, 16, memory byte-address width
HI, 28, resident count at or above which a spill burst starts
LO, 4, resident count at or below which a fill burst starts (when spilled > 0)
CHUNK, 8, words moved per burst
MAXW, 1024, spill-area capacity in words
BASE, 16'h8000, spill-area byte base address

Ports:
clk  in  1  system clock (ctl.clk)
rst  in  1  synchronous active-high reset (ctl.rst)
push_i  in  1  AU stack op sPUSH accepted this cycle
pop_i  in  1  AU stack op sPOP accepted this cycle
sp_i  in  SPW  AU stack pointer (ring top index)
stall_o  out  1  holds AU (au_en=0) while a burst runs
ebr_addr_o  out  SPW  EBR port address
ebr_ren_o  out  1  EBR read enable
ebr_wen_o  out  1  EBR write enable
ebr_wdata_o  out  DSZ  EBR write data
ebr_rdata_i  in  DSZ  EBR read data, 1-cycle latency
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  1=write (spill), 0=read (fill)
mem_addr_o  out  ASZ  word byte address
mem_wdata_o  out  DSZ  spill data
mem_rdata_i  in  DSZ  fill data, valid with ack
mem_ack_i  in  1  one-cycle transfer acknowledge
cnt_o  out  SPW+1  resident entry count
ovf_o  out  1  sticky overflow
udf_o  out  1  sticky underflow

Behaviour:
- Reset: all outputs 0, state IDLE, cnt=0, spilled=0.
- Reset mid-burst aborts the burst: mem_req_o drops at the next edge and the memory transaction is abandoned.
- cnt update (IDLE only):
  - push alone: +1
  - pop alone: -1
  - push and pop together: unchanged
- push_i/pop_i are ignored while stall_o=1; the AU holds its op until stall_o is released.
- bottom = sp_i - cnt + 1, modulo DEPTH.
- Spill entry: in IDLE, cnt >= HI and spilled < MAXW -> SP_RD. stall_o rises in the same cycle as the decision (registered, visible the next cycle).
- SP_RD: ebr_ren_o=1, ebr_addr_o=bottom (one cycle) -> SP_WR.
- SP_WR: mem_req_o=1, mem_we_o=1, mem_addr_o = BASE + 4*spilled, mem_wdata_o = captured ebr_rdata_i. Held stable until mem_ack_i.
  - On ack: spilled+1, cnt-1, word counter+1.
  - Next state: SP_RD if the counter < CHUNK and spilled < MAXW; otherwise IDLE.
- Fill entry: in IDLE, cnt <= LO and spilled > 0 -> FL_RD.
- FL_RD: mem_req_o=1, mem_we_o=0, mem_addr_o = BASE + 4*(spilled-1).
  - On ack: capture mem_rdata_i -> FL_WR.
- FL_WR: ebr_wen_o=1, ebr_addr_o = bottom-1, ebr_wdata_o = captured data.
  - Then spilled-1, cnt+1, counter+1.
  - Next state: FL_RD if the counter < CHUNK and spilled > 0; otherwise IDLE.
- Spill has priority over fill; HI > LO+CHUNK, so the two conditions never hold together.
- stall_o=1 in every non-IDLE state, released on return to IDLE.
- Spill-area full (spilled == MAXW) and push at cnt == DEPTH: ovf_o set, cnt saturates at DEPTH.
- Pop at cnt == 0 with spilled == 0: udf_o set, cnt stays 0.
- ovf_o/udf_o clear only on rst.
- Memory arithmetic: spilled is SPILLW = log2(MAXW)+1 bits; address = BASE + (spilled << 2), truncated to ASZ.
- EBR port ownership: the controller drives the EBR port only in non-IDLE states and keeps ren/wen=0 in IDLE. The external mux selects the controller when stall_o=1.

Decomposition:
- ej32_pkg additions:
  - ss_ctl_t enum {IDLE, SP_RD, SP_WR, FL_RD, FL_WR}
  - constants SS_HI, SS_LO, SS_CHUNK
- No sub-module. A single FSM with counters (cnt, spilled, burst counter) is natural.

Test Plan:
- Reset, then 27 pushes -> no stall. 28th push -> stall_o=1; 8 mem writes to 8000,8004…801C with data = first 8 pushed values; cnt=20, spilled=8.
- Continue with pops to cnt=4 -> fill: mem reads 801C down to 8000; EBR writes at bottom-1 descending; cnt=12, spilled=0; subsequent pop data order matches original push order.
- mem_ack_i delayed 5 cycles during SP_WR -> mem_req_o, mem_addr_o and mem_wdata_o stable all 5 cycles; single increment of spilled.
- Push and pop asserted together at cnt=10 -> cnt stays 10; no burst.
- MAXW=8 build: push to 32 after one spill -> no second spill; push at cnt=32 -> ovf_o=1, cnt=32. Pop at cnt=0, spilled=0 -> udf_o=1.
- rst asserted in SP_WR while mem_req_o=1 -> next cycle mem_req_o=0, stall_o=0, cnt=0, spilled=0, flags 0.
